round_key_sequencer: RTL and testbench

ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

---
 rtl/aes_pkg.sv | 27 ++
 rtl/round_key_sequencer_if.sv | 23 ++
 rtl/round_key_mux.sv | 16 +
 rtl/round_key_sequencer.sv | 111 +++++++++++
 tb/tb_round_key_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the round-key sequencer.
// Holds key geometry, the FSM state enum and the slot-extract function.
package aes_pkg;

  localparam int KEY_W       = 128;
  localparam int NUM_RK      = 11;
  localparam int RK_BUNDLE_W = KEY_W * NUM_RK;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // rk0 sits in the top KEY_W bits of the bundle.
  // Out-of-range indices read as zero.
  function automatic logic [KEY_W-1:0] rk_slot(
    input logic [RK_BUNDLE_W-1:0] bundle,
    input logic [3:0]             k
  );
    rk_slot = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (k == 4'(i))
        rk_slot = bundle[RK_BUNDLE_W-1-KEY_W*i -: KEY_W];
    end
  endfunction

endpackage

// File: rtl/round_key_sequencer_if.sv
// Round-key stream handshake bundle.
// master drives the key stream, slave returns ready.
interface round_key_sequencer_if #(
  parameter int KEY_W = 128
);

  logic [KEY_W-1:0] rk;
  logic [3:0]       rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;

  modport master (
    output rk, rk_idx, rk_valid, rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk, rk_idx, rk_valid, rk_last,
    output rk_ready
  );

endinterface

// File: rtl/round_key_mux.sv
// 11:1 round-key select from the stored bundle.
// Purely combinational.
module round_key_mux
  import aes_pkg::*;
(
  input  logic [RK_BUNDLE_W-1:0] bundle,
  input  logic [3:0]             idx,
  output logic [KEY_W-1:0]       rk
);

  // select slot idx
  always_comb begin
    rk = rk_slot(bundle, idx);
  end

endmodule

// File: rtl/round_key_sequencer.sv
// Streams a captured round-key bundle in encrypt or decrypt order.
// Define AES_KEY_ZEROIZE_EN to wipe keys after use and mask idle rk.
module round_key_sequencer #(
  parameter int KEY_W  = 128,
  parameter int NUM_RK = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    mode,
  input  logic [KEY_W*NUM_RK-1:0] keys_in,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  round_key_sequencer_if.master   rk_if
);

  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NUM_RK - 1);

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic [KEY_W*NUM_RK-1:0] bundle_q, bundle_d;
  logic                    done_d;
  logic                    is_last;
  logic                    xfer;
  logic [KEY_W-1:0]        slot;

  assign is_last = mode_q ? (idx_q == LAST)
                          : (idx_q == 4'd0);
  assign xfer    = (state_q == STREAM) &&
                   rk_if.rk_ready;

  // next state, counter step and capture
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    bundle_d = bundle_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
`ifdef AES_KEY_ZEROIZE_EN
      bundle_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_d  = STREAM;
            mode_d   = mode;
            bundle_d = keys_in;
            idx_d    = mode ? 4'd0 : LAST;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (is_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
              bundle_d = '0;
`endif
            end else if (mode_q) begin
              idx_d = idx_q + 4'd1;
            end else begin
              idx_d = idx_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, counter, bundle and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      mode_q   <= 1'b0;
      bundle_q <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      bundle_q <= bundle_d;
      done     <= done_d;
    end
  end

  round_key_mux u_mux (
    .bundle (bundle_q),
    .idx    (idx_q),
    .rk     (slot)
  );

  assign busy           = (state_q == STREAM);
  assign rk_if.rk_valid = busy;
  assign rk_if.rk_last  = busy && is_last;
  assign rk_if.rk_idx   = idx_q;
`ifdef AES_KEY_ZEROIZE_EN
  assign rk_if.rk       = busy ? slot : '0;
`else
  assign rk_if.rk       = slot;
`endif

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer with FIPS-197 key expansion.
// Covers reset, both orders, backpressure, load edges, flush and rst.
module tb_round_key_sequencer;

`ifdef AES_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          mode;
  logic          flush;
  logic [1407:0] keys_in;
  logic          busy;
  logic          done;
  logic [127:0]  rkx [0:10];

  int n_vec = 0;
  int n_err = 0;

  round_key_sequencer_if #(.KEY_W(128)) rk_if ();

  round_key_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .mode    (mode),
    .keys_in (keys_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .rk_if   (rk_if)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_i;
    int xfers;
    logic [31:0] pat;

    rkx[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rkx[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rkx[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rkx[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rkx[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rkx[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rkx[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rkx[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rkx[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rkx[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rkx[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int k = 0; k < 11; k++)
      keys_in[1407-128*k -: 128] = rkx[k];

    rst   = 1'b1;
    load  = 1'b0;
    mode  = 1'b0;
    flush = 1'b0;
    rk_if.rk_ready = 1'b0;

    #12;
    check("rst_valid", 128'(rk_if.rk_valid), 128'(0));
    check("rst_last",  128'(rk_if.rk_last),  128'(0));
    check("rst_busy",  128'(busy),           128'(0));
    check("rst_done",  128'(done),           128'(0));
    check("rst_idx",   128'(rk_if.rk_idx),   128'(0));
    check("rst_rk",    rk_if.rk,             128'(0));

    // decrypt stream, ready held high
    @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b1;
    mode = 1'b0;
    rk_if.rk_ready = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check("dec_valid", 128'(rk_if.rk_valid), 128'(1));
      check("dec_rk",    rk_if.rk,             rkx[10-k]);
      check("dec_idx",   128'(rk_if.rk_idx),   128'(10-k));
      check("dec_last",  128'(rk_if.rk_last),  128'(k == 10));
      tick();
    end
    check("dec_end_valid", 128'(rk_if.rk_valid), 128'(0));
    check("dec_done",      128'(done),           128'(1));
    check("dec_end_busy",  128'(busy),           128'(0));
    check("dec_end_idx",   128'(rk_if.rk_idx),   128'(0));
    check("dec_idle_rk",   rk_if.rk,
          ZEROIZE ? 128'(0) : rkx[0]);
    tick();
    check("dec_done_once", 128'(done), 128'(0));

    // encrypt stream; load on final transfer, then on done
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check("enc_rk",   rk_if.rk,            rkx[k]);
      check("enc_idx",  128'(rk_if.rk_idx),  128'(k));
      check("enc_last", 128'(rk_if.rk_last), 128'(k == 10));
      if (k == 10) begin
        load = 1'b1;
        mode = 1'b0;
      end
      tick();
    end
    check("ld_last_ign", 128'(rk_if.rk_valid), 128'(0));
    check("enc_done",    128'(done),           128'(1));
    tick();
    load = 1'b0;
    check("ld_done_val", 128'(rk_if.rk_valid), 128'(1));
    check("ld_done_idx", 128'(rk_if.rk_idx),   128'(10));
    check("ld_done_rk",  rk_if.rk,             rkx[10]);
    check("ld_done_dn",  128'(done),           128'(0));

    // backpressure on that decrypt stream
    pat   = 32'hB5C3_9A6D;
    exp_i = 10;
    xfers = 0;
    for (int c = 0; c < 100 && xfers < 11; c++) begin
      rk_if.rk_ready = pat[c % 32];
      check("bp_valid", 128'(rk_if.rk_valid), 128'(1));
      check("bp_rk",    rk_if.rk,             rkx[exp_i]);
      check("bp_idx",   128'(rk_if.rk_idx),   128'(exp_i));
      check("bp_last",  128'(rk_if.rk_last),  128'(exp_i == 0));
      if (rk_if.rk_ready) begin
        xfers++;
        if (exp_i > 0) exp_i--;
      end
      tick();
    end
    check("bp_count", 128'(xfers),          128'(11));
    check("bp_valid0", 128'(rk_if.rk_valid), 128'(0));
    check("bp_done",  128'(done),           128'(1));
    rk_if.rk_ready = 1'b1;

    // flush at idx 5 with simultaneous load
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    check("fl_idx", 128'(rk_if.rk_idx), 128'(5));
    flush = 1'b1;
    load  = 1'b1;
    tick();
    flush = 1'b0;
    load  = 1'b0;
    check("fl_valid", 128'(rk_if.rk_valid), 128'(0));
    check("fl_busy",  128'(busy),           128'(0));
    check("fl_done",  128'(done),           128'(0));
    check("fl_rk",    rk_if.rk,
          ZEROIZE ? 128'(0) : rkx[5]);
    tick();
    check("fl_done2",  128'(done),           128'(0));
    check("fl_valid2", 128'(rk_if.rk_valid), 128'(0));

    // asynchronous reset at idx 7
    load = 1'b1;
    mode = 1'b1;
    tick();
    load = 1'b0;
    repeat (7) tick();
    check("rs_idx7", 128'(rk_if.rk_idx), 128'(7));
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 128'(rk_if.rk_valid), 128'(0));
    check("rs_idx",   128'(rk_if.rk_idx),   128'(0));
    check("rs_rk",    rk_if.rk,             128'(0));
    check("rs_last",  128'(rk_if.rk_last),  128'(0));
    check("rs_busy",  128'(busy),           128'(0));
    tick();
    check("rs_done", 128'(done), 128'(0));
    rst  = 1'b0;
    load = 1'b1;
    mode = 1'b0;
    tick();
    load = 1'b0;
    check("rs_ld_val", 128'(rk_if.rk_valid), 128'(1));
    check("rs_ld_idx", 128'(rk_if.rk_idx),   128'(10));
    check("rs_ld_rk",  rk_if.rk,             rkx[10]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
